// File: rtl/im_wr_arbiter.sv
// Image-memory write-port arbiter: two round-robin requesters plus a clear engine
// that fills DEPTH words with a constant and has absolute priority. Port outputs are registered.
module im_wr_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_clear_value;
  logic              r_done;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_wren;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_count_last;
  logic              w_start;

  assign w_count_last = (r_count == LAST_WORD);
  assign w_start      = (r_state == S_IDLE) && clear_start;

  // Handshake: a write transfers in any cycle where valid && ready; ready is a
  // combinational grant, never high without its valid, and at most one is high.
  always_comb begin
    w_state_next = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_start) begin
          w_state_next = S_CLEAR;
        end else begin
          w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
          w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
        end
      end
      S_CLEAR: begin
        if (w_count_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_count       <= '0;
      r_clear_value <= '0;
      r_done        <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == S_CLEAR) && w_count_last;
      if (w_start) r_clear_value <= clear_value;
      // Terminal test is equality, so DEPTH == 2**ADDR_W needs no extra counter bit.
      if (r_state == S_CLEAR) r_count <= w_count_last ? '0 : r_count + 1'b1;
      else                    r_count <= '0;
      if (r_state == S_CLEAR) begin
        r_mem_address <= r_count;
        r_mem_data    <= r_clear_value;
        r_mem_wren    <= 1'b1;
      end else if (w_gnt0) begin
        r_mem_address <= req0_address;
        r_mem_data    <= req0_data;
        r_mem_wren    <= 1'b1;
      end else if (w_gnt1) begin
        r_mem_address <= req1_address;
        r_mem_data    <= req1_data;
        r_mem_wren    <= 1'b1;
      end else begin
        r_mem_wren    <= 1'b0;
      end
      if (w_gnt0)      r_last_grant <= 1'b0;
      else if (w_gnt1) r_last_grant <= 1'b1;
    end
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign clear_busy  = (r_state == S_CLEAR);
  assign clear_done  = r_done;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_wren    = r_mem_wren;
  assign dbg_state   = r_state;

endmodule
